// File: rtl/bitonic_sort_seq_pkg.sv
// Shared definitions for the bitonic sort sequencer: lane geometry, pad value,
// FSM state encoding and the lane-slice offset helper.
package bitonic_sort_seq_pkg;

  localparam int W_DEF = 8;
  localparam int N_DEF = 8;
  localparam logic [W_DEF-1:0] PAD_DEF = {W_DEF{1'b1}};

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } state_t;

  // Low bit of lane k in a flattened lane vector: use as [lane_lo(k, w) +: w].
  function automatic int lane_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/bitonic_sort_seq_frame_buffer.sv
// N x W lane register file: indexed write with optional pad-above-index,
// bulk load from a flattened vector, indexed read and flattened view.
module sort_frame_buffer
  import bitonic_sort_seq_pkg::*;
#(
  parameter int             W       = W_DEF,
  parameter int             N       = N_DEF,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter logic [W-1:0]   PAD_VAL = '1,
  localparam int            IW      = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_wr_en,
  input  logic [IW-1:0]     i_wr_idx,
  input  logic [W-1:0]      i_wr_data,
  input  logic              i_pad_above,
  input  logic              i_load,
  input  logic [N*W-1:0]    i_load_data,
  input  logic [IW-1:0]     i_rd_idx,
  output logic [W-1:0]      o_rd_data,
  output logic [N*W-1:0]    o_flat
);

  logic [W-1:0] r_lane [N];

  // Priority: clear, then bulk load, then indexed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) r_lane[k] <= RST_VAL;
    end else if (i_clear) begin
      for (int k = 0; k < N; k++) r_lane[k] <= RST_VAL;
    end else if (i_load) begin
      for (int k = 0; k < N; k++) r_lane[k] <= i_load_data[lane_lo(k, W) +: W];
    end else if (i_wr_en) begin
      for (int k = 0; k < N; k++) begin
        if (k == int'(i_wr_idx)) begin
          r_lane[k] <= i_wr_data;
        end else if (i_pad_above && (k > int'(i_wr_idx))) begin
          r_lane[k] <= PAD_VAL;
        end
      end
    end
  end

  assign o_rd_data = r_lane[i_rd_idx];

  for (genvar g = 0; g < N; g++) begin : g_flat
    assign o_flat[lane_lo(g, W) +: W] = r_lane[g];
  end

endmodule

// File: rtl/bitonic_sort_seq.sv
// Sequencer that gathers a serial stream into an N-lane frame, launches it into
// the shared bitonic sorter, captures the result and streams the real words out.
module bitonic_sort_seq
  import bitonic_sort_seq_pkg::*;
#(
  parameter int           W        = W_DEF,
  parameter int           N        = N_DEF,
  parameter int           SORT_LAT = 1,
  parameter logic [W-1:0] PAD      = {W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [W-1:0]    s_data,
  input  logic            s_last,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [W-1:0]    m_data,
  output logic            m_last,
  output logic            sort_start,
  output logic [N*W-1:0]  sort_data_o,
  input  logic [N*W-1:0]  sort_data_i,
  output logic            busy
);

  localparam int IW = $clog2(N);
  localparam int NW = IW + 1;

  state_t          r_state;
  logic [IW-1:0]   r_slot;
  logic [IW-1:0]   r_j;
  logic [NW-1:0]   r_n;
  logic [3:0]      r_cnt;
  logic            r_s_ready;
  logic            r_m_valid;
  logic            r_start;
  logic            r_busy;

  logic            w_accept;
  logic            w_frame_end;
  logic            w_beat;
  logic            w_last_beat;
  logic            w_capture;
  logic [W-1:0]    w_unused_rd;
  logic [N*W-1:0]  w_unused_flat;

  assign w_accept    = s_valid && r_s_ready && (r_state == ST_FILL);
  assign w_frame_end = w_accept && (s_last || (r_slot == IW'(N - 1)));
  assign w_beat      = r_m_valid && m_ready;
  assign w_last_beat = w_beat && m_last;
  assign w_capture   = (r_state == ST_WAIT) && (r_cnt == 4'd1);

  assign s_ready    = r_s_ready;
  assign m_valid    = r_m_valid;
  assign m_last     = r_m_valid && ({1'b0, r_j} == (r_n - NW'(1)));
  assign sort_start = r_start;
  assign busy       = r_busy;

  // Input frame: cleared back to PAD once the last output beat drains.
  sort_frame_buffer #(
    .W(W), .N(N), .RST_VAL(PAD), .PAD_VAL(PAD)
  ) u_in_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_last_beat),
    .i_wr_en     (w_accept),
    .i_wr_idx    (r_slot),
    .i_wr_data   (s_data),
    .i_pad_above (w_frame_end),
    .i_load      (1'b0),
    .i_load_data ('0),
    .i_rd_idx    ('0),
    .o_rd_data   (w_unused_rd),
    .o_flat      (sort_data_o)
  );

  // Result buffer resets to zero so m_data reads 0 out of reset.
  sort_frame_buffer #(
    .W(W), .N(N), .RST_VAL('0), .PAD_VAL(PAD)
  ) u_res_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (1'b0),
    .i_wr_en     (1'b0),
    .i_wr_idx    ('0),
    .i_wr_data   ('0),
    .i_pad_above (1'b0),
    .i_load      (w_capture),
    .i_load_data (sort_data_i),
    .i_rd_idx    (r_j),
    .o_rd_data   (m_data),
    .o_flat      (w_unused_flat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FILL;
      r_slot    <= '0;
      r_j       <= '0;
      r_n       <= '0;
      r_cnt     <= '0;
      r_s_ready <= 1'b0;
      r_m_valid <= 1'b0;
      r_start   <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_FILL: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
            r_slot <= r_slot + IW'(1);
            if (w_frame_end) begin
              r_n       <= {1'b0, r_slot} + NW'(1);
              r_slot    <= '0;
              r_s_ready <= 1'b0;
              r_start   <= 1'b1;
              r_busy    <= 1'b1;
              r_state   <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          r_cnt   <= 4'(SORT_LAT);
          r_state <= ST_WAIT;
        end
        // Counter reaching 1 marks the cycle whose closing edge captures the sorter.
        ST_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_j       <= '0;
            r_m_valid <= 1'b1;
            r_state   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_beat) begin
            r_j <= r_j + IW'(1);
            if (m_last) begin
              r_j       <= '0;
              r_n       <= '0;
              r_cnt     <= '0;
              r_m_valid <= 1'b0;
              r_busy    <= 1'b0;
              r_s_ready <= 1'b1;
              r_state   <= ST_FILL;
            end
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_bitonic_sort_seq.sv
// Scoreboard bench for bitonic_sort_seq with a behavioural sorter of latency LAT.
module tb_bitonic_sort_seq;

  localparam int W   = 8;
  localparam int N   = 8;
  localparam int LAT = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           s_valid = 1'b0;
  logic           s_ready;
  logic [W-1:0]   s_data = '0;
  logic           s_last = 1'b0;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [W-1:0]   m_data;
  logic           m_last;
  logic           sort_start;
  logic [N*W-1:0] sort_data_o;
  logic [N*W-1:0] sort_data_i;
  logic           busy;

  always #5 clk = ~clk;

  bitonic_sort_seq #(.W(W), .N(N), .SORT_LAT(LAT), .PAD(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .sort_start(sort_start), .sort_data_o(sort_data_o), .sort_data_i(sort_data_i),
    .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [W-1:0] d; logic l; } beat_t;
  beat_t          exp_q[$];
  logic [N*W-1:0] exp_lanes = '1;
  int             mode = 0;
  int             beats = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [N*W-1:0] sort_flat(input logic [N*W-1:0] v);
    logic [W-1:0]   q[$];
    logic [N*W-1:0] r;
    for (int k = 0; k < N; k++) q.push_back(v[k*W +: W]);
    q.sort();
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = q[k];
    return r;
  endfunction

  // Behavioural sorter: result valid only during cycle L0+LAT, inverted junk otherwise.
  logic [N*W-1:0] snap = '1;
  logic [N*W-1:0] sorted_v = '0;
  int             age = 15;
  assign sort_data_i = (age == LAT) ? sorted_v : ~sorted_v;

  always @(negedge clk) begin
    if (rst_n && sort_start) begin
      snap     = sort_data_o;
      sorted_v = sort_flat(sort_data_o);
      age      = 0;
      check("launch_lanes", 64'(sort_data_o), 64'(exp_lanes));
    end else if (age < 15) begin
      age++;
      if (rst_n && age <= LAT) check("lanes_held", 64'(sort_data_o), 64'(snap));
    end
  end

  // Monitor: pops the scoreboard on every accepted output beat.
  int   cyc = 0;
  int   start_cyc = 0;
  int   starts = 0;
  logic prev_stall = 1'b0;
  logic prev_mv = 1'b0;
  logic [W-1:0] prev_d = '0;
  logic prev_l = 1'b0;
  beat_t e;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      prev_mv    = 1'b0;
      starts     = 0;
    end else begin
      if (sort_start) begin
        starts++;
        start_cyc = cyc;
      end
      if (m_valid) check("sready_low_in_drain", 64'(s_ready), 64'(0));
      if (m_valid && !prev_mv) begin
        check("launch_to_valid", 64'(cyc - start_cyc), 64'(LAT + 1));
        check("one_start", 64'(starts), 64'(1));
      end
      if (prev_stall) check("stall_hold", 64'({m_valid, m_data, m_last}), 64'({1'b1, prev_d, prev_l}));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'(m_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("m_data", 64'(m_data), 64'(e.d));
          check("m_last", 64'(m_last), 64'(e.l));
        end
        beats++;
        if (m_last) starts = 0;
      end
      prev_stall = m_valid && !m_ready;
      prev_d     = m_data;
      prev_l     = m_last;
      prev_mv    = m_valid;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       m_ready = 1'b1;
        1:       m_ready = ~m_ready;
        default: m_ready = 1'($urandom_range(1));
      endcase
    end
  end

  task automatic send_frame(input logic [W-1:0] w[$], input bit use_last);
    int n;
    logic [W-1:0] s[$];
    bit ok;
    int t;
    n = w.size();
    s = w;
    s.sort();
    for (int i = 0; i < n; i++) exp_q.push_back({s[i], 1'(i == n - 1)});
    exp_lanes = '1;
    for (int i = 0; i < n; i++) exp_lanes[i*W +: W] = w[i];
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        s_valid = 1'b0; s_last = 1'b1; s_data = 8'($urandom);
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = w[i];
      s_last  = (i == n - 1) && (use_last || n < N);
      ok = 1'b0;
      t  = 0;
      while (!ok && t < 200) begin
        @(negedge clk);
        ok = s_ready;
        @(posedge clk); #1;
        t++;
      end
      if (!ok) check("input_handshake_timeout", 64'(0), 64'(1));
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(exp_q.size() == 0 && s_ready) && t < 500);
    check("idle_reached", 64'(t < 500), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic random_frame(output logic [W-1:0] w[$]);
    int n;
    w.delete();
    n = $urandom_range(N, 1);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(3))
        0:       w.push_back(8'h00);
        1:       w.push_back(8'hFF);
        default: w.push_back(8'($urandom));
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] fr[$];
  int base;
  int t;

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check("rst_s_ready", 64'(s_ready), 64'(0));
    check("rst_m_valid", 64'(m_valid), 64'(0));
    check("rst_m_last", 64'(m_last), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_sort_start", 64'(sort_start), 64'(0));
    check("rst_m_data", 64'(m_data), 64'(0));
    check("rst_lanes_pad", 64'(sort_data_o), 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("s_ready_before_edge", 64'(s_ready), 64'(0));
    @(negedge clk);
    check("s_ready_rises", 64'(s_ready), 64'(1));
    @(posedge clk); #1;

    mode = 0;
    send_frame('{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd1, 8'd1}, 1'b0);
    wait_idle();

    send_frame('{8'd7, 8'd2, 8'd5}, 1'b1);
    wait_idle();

    mode = 1;
    send_frame('{8'd40, 8'd7, 8'd200, 8'd7, 8'd0, 8'd99, 8'd13, 8'd1}, 1'b1);
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    t = 0;
    while (t < 300) begin
      @(negedge clk);
      t++;
      if (s_ready) break;
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("drain_end_sready", 64'(s_ready), 64'(1));
    wait_idle();

    mode = 0;
    send_frame('{8'hFF}, 1'b1);
    wait_idle();
    send_frame('{8'd0, 8'd255, 8'd0}, 1'b1);
    wait_idle();

    base = beats;
    send_frame('{8'd50, 8'd60, 8'd10, 8'd20, 8'd70, 8'd30, 8'd80, 8'd40}, 1'b0);
    t = 0;
    while (beats < base + 2 && t < 500) begin
      @(negedge clk); #1;
      t++;
    end
    check("two_beats_before_abort", 64'(beats >= base + 2), 64'(1));
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("abort_m_valid", 64'(m_valid), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_s_ready", 64'(s_ready), 64'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("abort_s_ready_rises", 64'(s_ready), 64'(1));
    @(posedge clk); #1;
    send_frame('{8'd8, 8'd6}, 1'b1);
    wait_idle();

    for (int f = 0; f < 25; f++) begin
      mode = $urandom_range(2);
      random_frame(fr);
      send_frame(fr, 1'($urandom_range(1)));
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bitonic_sort_seq.md
Name: bitonic_sort_seq

Overview:
- Sequencer that time-shares the 8-lane bitonic sorter datapath with a serial valid/ready stream.
- Gathers up to 8 words into a frame and pads unused lanes.
- Launches the frame into the sorter, waits a fixed sorter latency, captures the result, and streams the real words back out in ascending order.
- Sits between the upstream producer and the sorter; it is the only master of the sorter inputs.

Parameters:
- W, 8, data word width (matches sorter lane width).
- N, 8, lanes per frame; fixed at 8 to match the sorter.
- SORT_LAT, 1, cycles from sort_data_o valid to sort_data_i valid; legal range 1..15.
- PAD, {W{1'b1}}, fill value for unused lanes (all-ones, so padding sorts to the top).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  W  input word.
- s_last  in  1  marks the final word of a frame.
- m_valid  out  1  sorted output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  W  sorted output word.
- m_last  out  1  final real word of the frame.
- sort_start  out  1  one-cycle launch pulse to the sorter.
- sort_data_o  out  N*W  sorter lane inputs; lane k at [k*W +: W] (lane 0 = in1).
- sort_data_i  in  N*W  sorter lane outputs; lane 0 (out1) is the smallest.
- busy  out  1  high in every state except FILL.

Behaviour:
- Reset (async, rst_n low):
  - State = FILL; slot index, count and latency counter = 0.
  - s_ready = 0; m_valid, m_last, sort_start, busy = 0.
  - sort_data_o = all PAD; m_data = 0.
  - s_ready is registered and rises the first cycle after rst_n deasserts.
- FILL state:
  - s_ready = 1.
  - Each accepted word is written to lane k, where k = slot index; k then increments.
  - If the accepted word has s_last = 1 or k == N-1:
    - n = k+1 is recorded.
    - Lanes k+1..N-1 are set to PAD in the same edge.
    - s_ready drops and the next state is LAUNCH.
  - s_valid with s_ready = 0 is ignored (no capture).
- LAUNCH state (one cycle, call it L0):
  - sort_start = 1; sort_data_o is stable.
  - Next state is WAIT with counter = SORT_LAT.
- WAIT state (cycles L0+1..L0+SORT_LAT):
  - Counter decrements each cycle.
  - sort_data_o is held unchanged from L0 until WAIT exits.
  - sort_data_i is captured into the result buffer at the end of cycle L0+SORT_LAT.
  - Next state is DRAIN.
- Launch-to-output timing: first m_valid appears SORT_LAT+1 cycles after sort_start.
- DRAIN state:
  - m_valid = 1, m_data = result lane j (j starts at 0), m_last = (j == n-1).
  - On m_valid && m_ready, j increments.
  - On the beat with m_last, the next state is FILL: s_ready = 1 next cycle, lanes reset to PAD, counters cleared.
  - m_data and m_last stay stable while m_valid && !m_ready.
  - Only n beats are emitted; padding lanes are never emitted.
- No overlap: s_ready = 0 in LAUNCH, WAIT and DRAIN. Next-frame fill starts only after the last beat drains.
- Boundary conditions:
  - s_last on the first word gives n = 1, a single-beat output with m_last = 1.
  - Real data equal to PAD is correct: equal values are interchangeable and exactly n are emitted.
  - A frame of exactly N words with s_last on word N-1 is treated the same as one without s_last.
  - s_last is ignored when s_valid = 0.
  - rst_n asserted in any state aborts the frame immediately and asynchronously. Partial data is discarded, no stale words are emitted, and the next frame behaves as after a cold reset.
- Widths: the slot index and j are 3 bits (log2 N); n is 4 bits (1..8); the latency counter is 4 bits.

Decomposition:
- Shared package holds:
  - W and N defaults, and the PAD constant.
  - State encoding FILL=0, LAUNCH=1, WAIT=2, DRAIN=3.
  - The lane-slice helper [k*W +: W].
- Sub-module sort_frame_buffer: N×W register file with indexed write, pad-above-index, bulk load from sort_data_i, and indexed read.
  - One instance serves as the input frame.
  - One instance serves as the result buffer.
- The FSM and counters stay in bitonic_sort_seq.

Test Plan:
- Full frame: 3,1,4,1,5,9,1,1 with m_ready = 1.
  - Output is 1,1,1,1,3,4,5,9 with m_last only on 9.
  - Exactly one sort_start pulse; m_valid first appears SORT_LAT+1 cycles after it.
- Short frame: 7,2,5 with s_last on 5.
  - sort_data_o lanes 3..7 = 8'hFF during LAUNCH/WAIT.
  - Output is 2,5,7 with m_last on 7, exactly 3 beats, then s_ready = 1.
- Backpressure: full frame with m_ready toggling 1,0,1,0...
  - m_data and m_last are held while stalled; all 8 words arrive in order.
  - s_ready stays 0 throughout DRAIN even with s_valid = 1.
- Edge values: single word 8'hFF with s_last → one beat of 8'hFF with m_last = 1.
  - Then frame 0,255,0 → 0,0,255.
- Reset mid-operation: assert rst_n low after 2 DRAIN beats.
  - m_valid, busy and s_ready go to 0 without waiting for clk.
  - After release, frame 8,6 → output 6,8 with no residue from the aborted frame.
- Latency: SORT_LAT = 3 with a model sorter whose output is valid only at L0+3.
  - The capture is correct, and sort_data_o is unchanged over L0..L0+3.
